// File: rtl/iob_wb2iob.sv
// Wishbone-classic slave to IOb-native master bridge.
// Carries one MAC DMA transfer at a time onto the IOb memory bus. The request
// is registered, the Wishbone response is a single-cycle ack/err pulse, and a
// bus-fault timeout stops a dead memory target from hanging the MAC.
//
// Handshake summary:
//   Wishbone side: a transfer starts when wb_cyc_i & wb_stb_i are seen in IDLE;
//     cyc/stb are ignored in every other state. It ends with exactly one cycle
//     of wb_ack_o (success) or wb_err_o (timeout), and only if wb_cyc_i was
//     still high when the IOb side finished. A MAC that drops wb_cyc_i early
//     gets no response.
//   IOb side: m_valid rises with address/wdata/wstrb stable and stays high,
//     with those fields unchanged, until the cycle m_ready=1 is sampled or the
//     timeout expires. m_rdata is taken only in the m_ready cycle of a read.
module iob_wb2iob #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         wb_adr_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;
    // Set for a write with no byte selected: the transfer passes through REQ
    // for one cycle without touching the IOb bus, keeping the same ack timing
    // as the fastest real access.
    logic                 skip;

    // Byte-offset bits are dropped because IOb addresses are word aligned.
    logic                 unused_adr_bits;
    assign unused_adr_bits = ^wb_adr_i;

    assign dbg_state = state;

    // Transfer sequencer: IDLE latches the request, REQ waits for m_ready or
    // the timeout, RESP presents the one-cycle ack/err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            skip      <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            m_valid   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        m_address <= {wb_adr_i[ADDR_W-1:2], 2'b00};
                        m_wdata   <= wb_dat_i;
                        m_wstrb   <= wb_we_i ? wb_sel_i : '0;
                        cnt       <= '0;
                        state     <= REQ;
                        if (wb_we_i && (wb_sel_i == '0)) begin
                            skip    <= 1'b1;
                            m_valid <= 1'b0;
                        end else begin
                            skip    <= 1'b0;
                            m_valid <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (skip) begin
                        skip     <= 1'b0;
                        wb_ack_o <= wb_cyc_i;
                        state    <= RESP;
                    end else if (m_ready) begin
                        // A read is the only access with an all-zero strobe here.
                        if (m_wstrb == '0) begin
                            wb_dat_o <= m_rdata;
                        end
                        m_valid  <= 1'b0;
                        wb_ack_o <= wb_cyc_i;
                        state    <= RESP;
                    end else if (cnt == CNT_MAX) begin
                        m_valid  <= 1'b0;
                        wb_err_o <= wb_cyc_i;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    m_valid  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
